// File: rtl/axi4s_vid_out_lite.sv
// ---------------------------------------------------------------------------
// axi4s_vid_out_lite
//
// AXI4-Stream to parallel video output bridge (single clock). Incoming video
// words are buffered in a small first-word-fall-through FIFO. The buffered
// stream is locked to an external timing generator: the frame-start word
// (tuser=1) must be at the FIFO head when the timing generator starts a frame.
// Registered vid_* timing and pixel data are driven toward the display path.
//
// Ports:
//   aclk, rst, aclken         clock, async active-high reset, clock enable
//   s_axis_video_t*           AXI4-Stream video slave (tuser=SOF, tlast=EOL)
//   vtg_*                     timing generator inputs
//   vid_de/vblank/hblank/vsync/hsync
//                             vtg_* delayed one cycle
//   vid_data                  popped pixel, aligned with vid_de (0 when no pop)
//   locked                    high while locked to the timing generator
//   underflow, sync_error     one-cycle error pulses
//   fifo_level                current FIFO occupancy
// ---------------------------------------------------------------------------
module axi4s_vid_out_lite #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned FIFO_ADDR_BITS   = 5,
  parameter int unsigned HYSTERESIS_LEVEL = 12
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic                    aclken,
  input  logic [DATA_WIDTH-1:0]   s_axis_video_tdata,
  input  logic                    s_axis_video_tvalid,
  output logic                    s_axis_video_tready,
  input  logic                    s_axis_video_tuser,
  input  logic                    s_axis_video_tlast,
  input  logic                    vtg_active_video,
  input  logic                    vtg_vblank,
  input  logic                    vtg_hblank,
  input  logic                    vtg_vsync,
  input  logic                    vtg_hsync,
  output logic                    vid_de,
  output logic                    vid_vblank,
  output logic                    vid_hblank,
  output logic                    vid_vsync,
  output logic                    vid_hsync,
  output logic [DATA_WIDTH-1:0]   vid_data,
  output logic                    locked,
  output logic                    underflow,
  output logic                    sync_error,
  output logic [FIFO_ADDR_BITS:0] fifo_level
);

  localparam int unsigned DEPTH = 2**FIFO_ADDR_BITS;
  localparam int unsigned EW    = DATA_WIDTH + 2;

  localparam logic [FIFO_ADDR_BITS:0]   LVL_FULL = (FIFO_ADDR_BITS+1)'(DEPTH);
  localparam logic [FIFO_ADDR_BITS:0]   LVL_HYST = (FIFO_ADDR_BITS+1)'(HYSTERESIS_LEVEL);
  localparam logic [FIFO_ADDR_BITS:0]   LVL_ONE  = (FIFO_ADDR_BITS+1)'(1);
  localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = FIFO_ADDR_BITS'(1);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_WAIT_FRAME,
    ST_LOCKED
  } state_t;

  // FIFO storage: entry = {tuser, tlast, tdata}
  logic [EW-1:0]             r_mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] r_wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] r_rd_ptr;
  logic [FIFO_ADDR_BITS:0]   r_level;

  state_t                    r_state;
  logic                      r_vblank_seen;
  logic                      r_locked;
  logic                      r_underflow;
  logic                      r_sync_error;
  logic [DATA_WIDTH-1:0]     r_vid_data;
  logic                      r_vid_de;
  logic                      r_vid_vblank;
  logic                      r_vid_hblank;
  logic                      r_vid_vsync;
  logic                      r_vid_hsync;

  logic                      w_full;
  logic                      w_empty;
  logic                      w_wr;
  logic                      w_pop;
  logic                      w_fs;
  logic                      w_level_ok;
  logic                      w_head_user;
  logic [DATA_WIDTH-1:0]     w_head_data;

  assign w_full      = (r_level == LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_level_ok  = (r_level >= LVL_HYST);
  assign w_head_user = r_mem[r_rd_ptr][EW-1];
  assign w_head_data = r_mem[r_rd_ptr][DATA_WIDTH-1:0];

  // Reset is folded in so the master never sees tready while the FIFO is
  // being cleared.
  assign s_axis_video_tready = aclken & ~w_full & ~rst;
  assign w_wr                = s_axis_video_tvalid & s_axis_video_tready;

  // Frame start: first active pixel after a vertical blanking interval.
  assign w_fs = vtg_active_video & r_vblank_seen;

  // Pop decision per state; all pops are gated by the clock enable.
  always_comb begin
    w_pop = 1'b0;
    if (aclken) begin
      case (r_state)
        ST_UNLOCKED:   w_pop = ~w_empty & ~w_head_user;
        ST_WAIT_FRAME: w_pop = w_fs & w_level_ok;
        ST_LOCKED:     w_pop = vtg_active_video & ~w_empty;
        default:       w_pop = 1'b0;
      endcase
    end
  end

  // FIFO storage write (no reset needed: occupancy is tracked by r_level).
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Timing passthrough and frame-start tracking, independent of lock state.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_vid_de      <= 1'b0;
      r_vid_vblank  <= 1'b0;
      r_vid_hblank  <= 1'b0;
      r_vid_vsync   <= 1'b0;
      r_vid_hsync   <= 1'b0;
      r_vblank_seen <= 1'b0;
    end else if (aclken) begin
      r_vid_de     <= vtg_active_video;
      r_vid_vblank <= vtg_vblank;
      r_vid_hblank <= vtg_hblank;
      r_vid_vsync  <= vtg_vsync;
      r_vid_hsync  <= vtg_hsync;
      if (vtg_active_video) begin
        r_vblank_seen <= 1'b0;
      end else if (vtg_vblank) begin
        r_vblank_seen <= 1'b1;
      end
    end
  end

  // Lock FSM with registered pixel and status outputs. Error pulses are
  // cleared while aclken is low so that each pulse lasts exactly one clock;
  // every other output register holds.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_UNLOCKED;
      r_locked     <= 1'b0;
      r_underflow  <= 1'b0;
      r_sync_error <= 1'b0;
      r_vid_data   <= '0;
    end else if (!aclken) begin
      r_underflow  <= 1'b0;
      r_sync_error <= 1'b0;
    end else begin
      r_underflow  <= 1'b0;
      r_sync_error <= 1'b0;
      r_vid_data   <= '0;
      case (r_state)
        ST_UNLOCKED: begin
          // Garbage ahead of a frame start is discarded by w_pop.
          if (!w_empty && w_head_user) begin
            r_state <= ST_WAIT_FRAME;
          end
        end
        ST_WAIT_FRAME: begin
          if (w_pop) begin
            r_vid_data <= w_head_data;
            r_state    <= ST_LOCKED;
            r_locked   <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (vtg_active_video) begin
            if (w_empty) begin
              // Underflow wins over any frame-start mismatch.
              r_underflow <= 1'b1;
              r_state     <= ST_UNLOCKED;
              r_locked    <= 1'b0;
            end else begin
              r_vid_data <= w_head_data;
              if (w_head_user != w_fs) begin
                r_sync_error <= 1'b1;
                r_state      <= ST_UNLOCKED;
                r_locked     <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state  <= ST_UNLOCKED;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign vid_de     = r_vid_de;
  assign vid_vblank = r_vid_vblank;
  assign vid_hblank = r_vid_hblank;
  assign vid_vsync  = r_vid_vsync;
  assign vid_hsync  = r_vid_hsync;
  assign vid_data   = r_vid_data;
  assign locked     = r_locked;
  assign underflow  = r_underflow;
  assign sync_error = r_sync_error;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_axi4s_vid_out_lite.sv
// ---------------------------------------------------------------------------
// tb_axi4s_vid_out_lite
//
// Randomized bench for axi4s_vid_out_lite. A queue-based reference model of
// the buffered stream and the lock rules predicts every output each cycle.
// Stimulus: a 4x2 active-pixel timing generator with blanking, a frame-
// structured stream source with random gaps, garbage bursts and dropped
// pixels, random aclken bursts, a starvation phase, a backpressure phase with
// the timing generator idle, and an asynchronous mid-run reset.
// ---------------------------------------------------------------------------
module tb_axi4s_vid_out_lite;

  localparam int DW    = 8;
  localparam int AB    = 5;
  localparam int HYST  = 12;
  localparam int DEPTH = 32;

  logic          aclk = 1'b0;
  logic          rst;
  logic          aclken;
  logic [DW-1:0] s_axis_video_tdata;
  logic          s_axis_video_tvalid;
  logic          s_axis_video_tready;
  logic          s_axis_video_tuser;
  logic          s_axis_video_tlast;
  logic          vtg_active_video, vtg_vblank, vtg_hblank, vtg_vsync, vtg_hsync;
  logic          vid_de, vid_vblank, vid_hblank, vid_vsync, vid_hsync;
  logic [DW-1:0] vid_data;
  logic          locked, underflow, sync_error;
  logic [AB:0]   fifo_level;

  axi4s_vid_out_lite #(
    .DATA_WIDTH      (DW),
    .FIFO_ADDR_BITS  (AB),
    .HYSTERESIS_LEVEL(HYST)
  ) dut (
    .aclk               (aclk),
    .rst                (rst),
    .aclken             (aclken),
    .s_axis_video_tdata (s_axis_video_tdata),
    .s_axis_video_tvalid(s_axis_video_tvalid),
    .s_axis_video_tready(s_axis_video_tready),
    .s_axis_video_tuser (s_axis_video_tuser),
    .s_axis_video_tlast (s_axis_video_tlast),
    .vtg_active_video   (vtg_active_video),
    .vtg_vblank         (vtg_vblank),
    .vtg_hblank         (vtg_hblank),
    .vtg_vsync          (vtg_vsync),
    .vtg_hsync          (vtg_hsync),
    .vid_de             (vid_de),
    .vid_vblank         (vid_vblank),
    .vid_hblank         (vid_hblank),
    .vid_vsync          (vid_vsync),
    .vid_hsync          (vid_hsync),
    .vid_data           (vid_data),
    .locked             (locked),
    .underflow          (underflow),
    .sync_error         (sync_error),
    .fifo_level         (fifo_level)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: buffered words {tuser,tlast,data}, lock flags.
  logic [DW+1:0] m_q[$];
  bit            m_locked, m_armed, m_vbs;

  // Expected registered outputs.
  logic          e_de, e_vblank, e_hblank, e_vsync, e_hsync;
  logic [DW-1:0] e_data;
  logic          e_locked, e_uf, e_se;
  logic [AB:0]   e_level;

  // Stimulus generator state.
  bit            vtg_on, src_en, err_en, ce_rand;
  int unsigned   src_rate, hcnt, vcnt, src_idx, garb, ce_burst;
  bit            src_pend;

  task automatic model_clear();
    m_q.delete();
    m_locked = 0; m_armed = 0; m_vbs = 0;
    e_de = 0; e_vblank = 0; e_hblank = 0; e_vsync = 0; e_hsync = 0;
    e_data = '0; e_locked = 0; e_uf = 0; e_se = 0; e_level = '0;
  endtask

  task automatic gen_word();
    if (garb > 0) begin
      s_axis_video_tuser = 1'b0; s_axis_video_tlast = 1'b0; garb--;
    end else if (err_en && src_idx == 0 && $urandom_range(39) == 0) begin
      s_axis_video_tuser = 1'b0; s_axis_video_tlast = 1'b0; garb = 4;
    end else begin
      if (err_en && $urandom_range(59) == 0) src_idx = (src_idx + 1) % 8;
      s_axis_video_tuser = (src_idx == 0);
      s_axis_video_tlast = (src_idx % 4 == 3);
      src_idx = (src_idx + 1) % 8;
    end
    s_axis_video_tdata = 8'($urandom);
    src_pend = 1;
  endtask

  task automatic compare_outputs();
    chk("vid_de", vid_de, e_de);
    chk("vid_vblank", vid_vblank, e_vblank);
    chk("vid_hblank", vid_hblank, e_hblank);
    chk("vid_vsync", vid_vsync, e_vsync);
    chk("vid_hsync", vid_hsync, e_hsync);
    chk("vid_data", vid_data, e_data);
    chk("locked", locked, e_locked);
    chk("underflow", underflow, e_uf);
    chk("sync_error", sync_error, e_se);
    chk("fifo_level", fifo_level, e_level);
  endtask

  task automatic cycle();
    logic [DW+1:0] e;
    bit fs, acc, exp_tready;
    @(negedge aclk);
    if (ce_burst > 0) begin
      aclken = 1'b0; ce_burst--;
    end else if (ce_rand && $urandom_range(59) == 0) begin
      aclken = 1'b0; ce_burst = 2;
    end else begin
      aclken = 1'b1;
    end
    vtg_active_video = vtg_on && vcnt < 2 && hcnt < 4;
    vtg_hblank       = vtg_on && hcnt >= 4;
    vtg_vblank       = vtg_on && vcnt >= 2;
    vtg_hsync        = vtg_on && hcnt == 5;
    vtg_vsync        = vtg_on && vcnt == 3;
    if (!src_pend && src_en && $urandom_range(99) < src_rate) gen_word();
    s_axis_video_tvalid = src_pend;
    #1;
    exp_tready = aclken && !rst && (m_q.size() < DEPTH);
    chk("tready", s_axis_video_tready, exp_tready);
    acc = src_pend && exp_tready;
    if (rst) begin
      model_clear();
    end else if (aclken) begin
      fs = vtg_active_video && m_vbs;
      e_data = '0; e_uf = 0; e_se = 0;
      if (m_locked) begin
        if (vtg_active_video) begin
          if (m_q.size() == 0) begin
            e_uf = 1; m_locked = 0;
          end else begin
            e = m_q.pop_front();
            e_data = e[DW-1:0];
            if (e[DW+1] != fs) begin e_se = 1; m_locked = 0; end
          end
        end
      end else if (m_armed) begin
        if (fs && m_q.size() >= HYST) begin
          e = m_q.pop_front();
          e_data = e[DW-1:0];
          m_locked = 1; m_armed = 0;
        end
      end else if (m_q.size() > 0) begin
        if (m_q[0][DW+1]) m_armed = 1;
        else void'(m_q.pop_front());
      end
      if (vtg_active_video) m_vbs = 0;
      else if (vtg_vblank) m_vbs = 1;
      e_de = vtg_active_video; e_vblank = vtg_vblank; e_hblank = vtg_hblank;
      e_vsync = vtg_vsync; e_hsync = vtg_hsync;
      if (acc) m_q.push_back({s_axis_video_tuser, s_axis_video_tlast, s_axis_video_tdata});
      e_locked = m_locked;
      e_level = (AB+1)'(m_q.size());
    end else begin
      e_uf = 0; e_se = 0;
    end
    if (acc) src_pend = 0;
    if (aclken && !rst && vtg_on) begin
      hcnt++;
      if (hcnt == 6) begin hcnt = 0; vcnt = (vcnt + 1) % 4; end
    end
    @(posedge aclk);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    compare_outputs();
    chk("tready_rst", s_axis_video_tready, 1'b0);
    src_pend = 0; src_idx = 0; garb = 0; hcnt = 0; vcnt = 0;
    s_axis_video_tvalid = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; aclken = 1'b1;
    s_axis_video_tdata = '0; s_axis_video_tvalid = 1'b0;
    s_axis_video_tuser = 1'b0; s_axis_video_tlast = 1'b0;
    vtg_active_video = 1'b0; vtg_vblank = 1'b0; vtg_hblank = 1'b0;
    vtg_vsync = 1'b0; vtg_hsync = 1'b0;
    vtg_on = 0; src_en = 0; err_en = 0; ce_rand = 0;
    src_rate = 80; hcnt = 0; vcnt = 0; src_idx = 0; garb = 0; ce_burst = 0; src_pend = 0;
    model_clear();

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;

    // Clean lock, then random stream with errors and aclken bursts
    vtg_on = 1; src_en = 1; src_rate = 80;
    repeat (300) cycle();
    err_en = 1; ce_rand = 1;
    repeat (1200) cycle();

    // Starvation: underflow, then recovery
    src_en = 0;
    repeat (80) cycle();
    src_en = 1;
    repeat (600) cycle();

    // Backpressure with the timing generator idle
    vtg_on = 0; err_en = 0; ce_rand = 0; src_rate = 100;
    repeat (80) cycle();
    vtg_on = 1;
    repeat (200) cycle();

    // Asynchronous reset mid-frame, then a slow source (hysteresis/underflow)
    do_reset();
    src_rate = 25; err_en = 1; ce_rand = 1;
    repeat (800) cycle();

    // Fast source again
    src_rate = 90;
    repeat (400) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
